// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder : latency-modelled byte-addressed data memory responder
// Optional perf counters: DATA_MEM_PERF_EN              Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic                 req_byte,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q;
  logic                    byte_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic [31:0]             resp_rdata_q;
  logic [31:0]             mem_q [WORDS];

  logic [ADDR_WIDTH-3:0]   widx;
  logic [31:0]             rd_word;
  logic [7:0]              rd_byte;
  logic [31:0]             mem_word_d;
  logic [31:0]             rd_data_d;
  logic                    done;
  logic                    unused_hi;

  assign unused_hi = ^req_addr[31:ADDR_WIDTH];
  assign widx      = addr_q[ADDR_WIDTH-1:2];
  assign rd_word   = mem_q[widx];
  assign done      = (state_q == BUSY) && (cnt_q == 4'd0);

  // Little-endian lane select; the merged word lets byte stores reuse a full-word write.
  always_comb begin
    rd_byte    = rd_word[7:0];
    mem_word_d = rd_word;
    case (addr_q[1:0])
      2'd0: begin rd_byte = rd_word[7:0];   mem_word_d[7:0]   = wdata_q[7:0]; end
      2'd1: begin rd_byte = rd_word[15:8];  mem_word_d[15:8]  = wdata_q[7:0]; end
      2'd2: begin rd_byte = rd_word[23:16]; mem_word_d[23:16] = wdata_q[7:0]; end
      default: begin rd_byte = rd_word[31:24]; mem_word_d[31:24] = wdata_q[7:0]; end
    endcase
    if (!byte_q) mem_word_d = wdata_q;
    if (we_q)        rd_data_d = 32'd0;
    else if (byte_q) rd_data_d = {24'd0, rd_byte};
    else             rd_data_d = rd_word;
  end

  // Memory contents survive reset; a write is suppressed if reset lands on its commit edge.
  always_ff @(posedge clk) begin
    if (!rst && done && we_q) mem_q[widx] <= mem_word_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            byte_q      <= req_byte;
            addr_q      <= req_addr[ADDR_WIDTH-1:0];
            wdata_q     <= req_wdata;
            cnt_q       <= 4'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rd_data_d;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_rdata_q <= 32'd0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

`ifdef DATA_MEM_PERF_EN
  logic [CNT_WIDTH-1:0] rd_cnt_q;
  logic [CNT_WIDTH-1:0] wr_cnt_q;

  // Counts step on the edge entering RESP so the new value is visible with the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (done) begin
      if (we_q) wr_cnt_q <= wr_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      else      rd_cnt_q <= rd_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// tb_data_mem_responder : directed + randomized bench with a byte-array model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;
  localparam int AW  = 17;
  localparam int LAT = 4;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic          req_byte;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wr_count;

  int checks   = 0;
  int failures = 0;
  int rd_n     = 0;
  int wr_n     = 0;
  logic [31:0] last_resp;
  logic [7:0]  mdl [0:(1<<AW)-1];

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic bt, input logic [31:0] a);
    int x;
    x = int'(a) & ((1 << AW) - 1);
    if (bt) return {24'd0, mdl[x]};
    x = x & ~3;
    return {mdl[x+3], mdl[x+2], mdl[x+1], mdl[x]};
  endfunction

  task automatic model_write(input logic bt, input logic [31:0] a, input logic [31:0] d);
    int x;
    x = int'(a) & ((1 << AW) - 1);
    if (bt) mdl[x] = d[7:0];
    else begin
      x = x & ~3;
      {mdl[x+3], mdl[x+2], mdl[x+1], mdl[x]} = d;
    end
  endtask

  task automatic check_counters(input string tag);
`ifdef DATA_MEM_PERF_EN
    chk({tag, "_rd_count"}, {16'd0, rd_count}, 32'(rd_n % (1 << CW)));
    chk({tag, "_wr_count"}, {16'd0, wr_count}, 32'(wr_n % (1 << CW)));
`else
    chk({tag, "_rd_count"}, {16'd0, rd_count}, 32'd0);
    chk({tag, "_wr_count"}, {16'd0, wr_count}, 32'd0);
`endif
  endtask

  // One full transaction; junk with req_valid=1 is driven while busy to show it is ignored.
  task automatic do_req(input logic we, input logic bt, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp;
    @(negedge clk);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_byte = bt; req_addr = a; req_wdata = d;
    exp = we ? 32'd0 : model_read(bt, a);
    @(posedge clk); #1;
    req_we = 1'($urandom); req_byte = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int j = 0; j < LAT; j++) begin
      @(negedge clk);
      chk("busy_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("resp_rdata", resp_rdata, exp);
    chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
    last_resp = resp_rdata;
    if (we) begin model_write(bt, a, d); wr_n++; end
    else rd_n++;
    @(negedge clk);
    req_valid = 1'b0;
    chk("after_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("after_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mdl[i] = 8'd0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    check_counters("reset");

    do_req(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("word_write_rdata", last_resp, 32'd0);
    do_req(1'b0, 1'b0, 32'h0000_0010, 32'd0);
    chk("word_read", last_resp, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b1, 32'h0000_0011, 32'h0000_00A5);
    do_req(1'b0, 1'b0, 32'h0000_0010, 32'd0);
    chk("word_after_sb", last_resp, 32'hDEAD_A5EF);
    do_req(1'b0, 1'b1, 32'h0000_0011, 32'd0);
    chk("lbu_11", last_resp, 32'h0000_00A5);
    do_req(1'b0, 1'b1, 32'h0000_0013, 32'd0);
    chk("lbu_13", last_resp, 32'h0000_00DE);
    do_req(1'b0, 1'b0, 32'h0002_0012, 32'd0);
    chk("alias_align", last_resp, 32'hDEAD_A5EF);

    // Reset during the second BUSY cycle of a write.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0;
    req_addr = 32'h0000_0020; req_wdata = 32'h1234_5678;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    rd_n = 0; wr_n = 0;
    for (int j = 0; j < LAT + 3; j++) begin
      @(negedge clk);
      chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    end
    check_counters("midrst");

    do_req(1'b0, 1'b0, 32'h0000_0020, 32'd0);
    chk("midrst_read_20", last_resp, 32'd0);
    do_req(1'b0, 1'b1, 32'h0000_0010, 32'd0);
    do_req(1'b0, 1'b0, 32'h0000_0010, 32'd0);
    do_req(1'b1, 1'b0, 32'h0000_0024, 32'h0BAD_F00D);
    do_req(1'b1, 1'b1, 32'h0000_0027, 32'h0000_0077);
    check_counters("perf_3r2w");
`ifdef DATA_MEM_PERF_EN
    chk("perf_rd_3", {16'd0, rd_count}, 32'd3);
    chk("perf_wr_2", {16'd0, wr_count}, 32'd2);
`endif

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFE_0000) | 32'($urandom_range(0, 63));
      do_req(1'($urandom), 1'($urandom), a, $urandom);
    end
    check_counters("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
